// File: rtl/next_pc_unit.sv
// next_pc_unit: program-counter register and next-PC selection.
// Handles sequential, branch, region-jump and register-jump targets. It also
// provides stall hold, an optional single delay slot, and a trap on misaligned
// targets.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | no delayed transfer outstanding
// ST_SLOT  | slot instruction being fetched; pending target loads next
module next_pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      JUMP_BITS    = 26,
  parameter int unsigned      IMM_BITS     = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
  parameter bit               DELAY_SLOT   = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 Stall,
  input  logic [1:0]           PCSrc,
  input  logic                 BranchTaken,
  input  logic [IMM_BITS-1:0]  Imm,
  input  logic [JUMP_BITS-1:0] JumpAddr,
  input  logic [WIDTH-1:0]     RegTarget,
  output logic [WIDTH-1:0]     PC,
  output logic [WIDTH-1:0]     PCPlus4,
  output logic [WIDTH-1:0]     PCJump,
  output logic                 SlotPending,
  output logic                 Misalign
);

  typedef enum logic {ST_RUN = 1'b0, ST_SLOT = 1'b1} state_t;

  localparam int unsigned EXT_BITS = WIDTH - IMM_BITS - 2;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             misalign_q, misalign_d;

  logic [WIDTH-1:0] branch_off;
  logic [WIDTH-1:0] target;
  logic             taken;
  logic             misaligned;

  assign PCPlus4    = pc_q + WIDTH'(4);
  // Region bits come from PC+4 so a jump in the last word of a region
  // lands in the following region, matching the fetch address of the slot.
  assign PCJump     = {PCPlus4[WIDTH-1:JUMP_BITS+2], JumpAddr, 2'b00};
  assign branch_off = {{EXT_BITS{Imm[IMM_BITS-1]}}, Imm, 2'b00};

  assign PC          = pc_q;
  assign SlotPending = (state_q == ST_SLOT);
  assign Misalign    = misalign_q;

  // Select the transfer target and decide whether the transfer is taken.
  always_comb begin
    target = PCPlus4;
    taken  = 1'b0;
    unique case (PCSrc)
      2'b01: begin
        target = PCPlus4 + branch_off;
        taken  = BranchTaken;
      end
      2'b10: begin
        target = PCJump;
        taken  = 1'b1;
      end
      2'b11: begin
        target = RegTarget;
        taken  = 1'b1;
      end
      default: begin
        target = PCPlus4;
        taken  = 1'b0;
      end
    endcase
    misaligned = taken && (target[1:0] != 2'b00);
  end

  // Next-state and next-PC selection in priority order; stall freezes everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    misalign_d = misalign_q;
    if (!Stall) begin
      misalign_d = 1'b0;
      if (misaligned) begin
        pc_d       = EXC_VECTOR;
        misalign_d = 1'b1;
        pending_d  = '0;
        state_d    = ST_RUN;
      end else if (state_q == ST_SLOT) begin
        // Any transfer requested by the slot instruction is dropped here.
        pc_d    = pending_q;
        state_d = ST_RUN;
      end else if (taken && !DELAY_SLOT) begin
        pc_d = target;
      end else if (taken) begin
        pc_d      = PCPlus4;
        pending_d = target;
        state_d   = ST_SLOT;
      end else begin
        pc_d = PCPlus4;
      end
    end
  end

  // PC, pending target, slot state and trap flag registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      pending_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Parametrised program-counter unit for the CPU: holds the PC register and computes the next PC from sequential, branch, region-jump or register-jump targets. It generalises the fixed 32-bit jump-target concatenation to configurable widths. It adds stall hold, an optional MIPS-style branch delay slot, and a trap on misaligned targets. It sits between the control unit/register file and the instruction memory address port.

## Interface
- WIDTH, 32, PC/address width; must be ≥ JUMP_BITS+3
- JUMP_BITS, 26, width of the instruction jump-index field
- IMM_BITS, 16, width of the branch offset field (signed, word units)
- RESET_VECTOR, 32'h0000_0000, PC value after reset (WIDTH bits)
- EXC_VECTOR, 32'h0000_0180, PC loaded on a misaligned target (WIDTH bits)
- DELAY_SLOT, 0, 1 = one architectural delay slot after each taken transfer

Ports:
- CLK  in  1  clock, rising edge
- RST_n  in  1  reset; one clock; reset is asynchronous and active-low
- Stall  in  1  hold PC and all internal state this cycle
- PCSrc  in  2  00 sequential, 01 branch, 10 region jump, 11 register jump
- BranchTaken  in  1  qualifies PCSrc=01; ignored otherwise
- Imm  in  IMM_BITS  signed branch offset in words
- JumpAddr  in  JUMP_BITS  jump index field
- RegTarget  in  WIDTH  register-jump target
- PC  out  WIDTH  current PC (registered)
- PCPlus4  out  WIDTH  PC+4 mod 2^WIDTH (combinational)
- PCJump  out  WIDTH  {PCPlus4[WIDTH-1:JUMP_BITS+2], JumpAddr, 2'b00} (combinational)
- SlotPending  out  1  registered; 1 while a delayed target is waiting
- Misalign  out  1  registered one-cycle pulse on a misaligned-target trap

## Operation
- Branch target = PCPlus4 + (sign-extend(Imm) << 2), computed modulo 2^WIDTH.
- Region jump target = PCJump. Upper bits come from PCPlus4, not PC.
- Register target = RegTarget, taken unmodified.
- Taken transfer = PCSrc=10, PCSrc=11, or (PCSrc=01 and BranchTaken).
- Misaligned = taken transfer whose target[1:0] ≠ 00. Only register jumps can produce it.
- Priority each non-stalled edge, highest first:
  - misaligned taken transfer → PC←EXC_VECTOR, Misalign←1, pending cleared;
  - SlotPending=1 → PC←pending target, SlotPending←0; current PCSrc is ignored, so a transfer issued in a slot is discarded;
  - taken transfer with DELAY_SLOT=0 → PC←target;
  - taken transfer with DELAY_SLOT=1 → PC←PCPlus4, pending←target, SlotPending←1;
  - otherwise → PC←PCPlus4.
- Misalign is 0 on every edge that does not trap.
- Stall=1: PC, pending, SlotPending and Misalign hold their values; all inputs are ignored. Misalign therefore stretches while stalled.
- Sequential wrap: PC=2^WIDTH−4 → next PC=0. No flag is raised.

## Timing
- Reset (asynchronous, RST_n=0): PC=RESET_VECTOR, SlotPending=0, Misalign=0, pending=0. Reset mid-slot discards the pending target.
- PC updates on the rising CLK edge after the cycle in which the request is presented. Latency to redirect:
  - DELAY_SLOT=0: 1 cycle;
  - DELAY_SLOT=1: 2 cycles, with exactly one slot instruction fetched in between.
- PCPlus4 and PCJump have zero latency from PC and JumpAddr.
- The first edge after RST_n deasserts performs a normal update from RESET_VECTOR.

## Test plan
- Reset then free-run, DELAY_SLOT=0, PCSrc=00 → PC sequence 0x0, 0x4, 0x8; at PC=0xFFFFFFFC the next PC is 0x00000000.
- Region jump: PC=0x80FFFFFC, JumpAddr=26'h2BBCCDD, PCSrc=10 → PCJump=0x8AEF3374 combinationally; PC=0x8AEF3374 after the edge.
- Branch: PC=0x00003000, Imm=16'hFFFF, PCSrc=01, BranchTaken=1 → PC=0x00003000. With BranchTaken=0 → PC=0x00003004.
- DELAY_SLOT=1: PC=0x100, register jump to 0x400 → PC=0x104 with SlotPending=1. Then present PCSrc=10 in the slot with Stall=1 for 2 cycles → PC holds 0x104. Release the stall → PC=0x400, SlotPending=0, slot jump discarded.
- Misalign: RegTarget=0x00400002, PCSrc=11 → PC=0x180 and Misalign=1 for one cycle, then 0.
- Assert RST_n=0 asynchronously while SlotPending=1 → PC=RESET_VECTOR immediately, SlotPending=0, and no redirect after release.
